kmem_rcfg_sequencer: RTL

Sequencer for the kernel-memory (KMEM) configuration slots. After a start command it steps the KMEM configuration address through the active slots, holding each slot for a programmed number of cycles and repeating the sequence for a programmed number of loops. The address it drives is the `rcfg_ctrl_addr` consumed by the load/store stream-select configuration muxes and the other per-slot configuration readers in the PEA. It sits between the control/status registers and the configuration-register decode.

---
 rtl/kmem_rcfg_sequencer_pkg.sv | 15 +
 rtl/kmem_rcfg_sequencer_if.sv | 35 +++
 rtl/kmem_rcfg_sequencer_dwell_cnt.sv | 32 +++
 rtl/kmem_rcfg_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/kmem_rcfg_sequencer_pkg.sv
// Shared types and sizing for the KMEM configuration-slot sequencer.
package kmem_rcfg_sequencer_pkg;

    localparam int KMEM_SIZE        = 8;
    localparam int N_ADDR_BITS_KMEM = $clog2(KMEM_SIZE);
    localparam int KMEM_ITER_W      = 8;
    localparam int KMEM_LOOP_W      = 8;

    typedef enum logic [1:0] {
        RCFG_IDLE = 2'd0,
        RCFG_RUN  = 2'd1,
        RCFG_DONE = 2'd2
    } rcfg_seq_state_e;

endpackage

// File: rtl/kmem_rcfg_sequencer_if.sv
// Control/status side of the sequencer: start/abort/stall, slot configuration and the
// rcfg_ctrl_addr stream consumed by the per-slot configuration readers.
interface kmem_rcfg_sequencer_if #(
    parameter int KMEM_SIZE        = kmem_rcfg_sequencer_pkg::KMEM_SIZE,
    parameter int N_ADDR_BITS_KMEM = $clog2(KMEM_SIZE),
    parameter int ITER_W           = kmem_rcfg_sequencer_pkg::KMEM_ITER_W,
    parameter int LOOP_W           = kmem_rcfg_sequencer_pkg::KMEM_LOOP_W
);
    logic                                 start_i;
    logic                                 abort_i;
    logic                                 stall_i;
    logic [N_ADDR_BITS_KMEM:0]            cfg_n_slots_i;
    logic [LOOP_W-1:0]                    cfg_n_loops_i;
    logic [KMEM_SIZE-1:0][ITER_W-1:0]     cfg_slot_iter_i;

    logic [N_ADDR_BITS_KMEM-1:0]          rcfg_ctrl_addr_o;
    logic                                 slot_valid_o;
    logic                                 slot_last_o;
    logic [LOOP_W-1:0]                    loop_cnt_o;
    logic                                 busy_o;
    logic                                 done_o;
    logic                                 cfg_err_o;

    modport master (
        output start_i, abort_i, stall_i, cfg_n_slots_i, cfg_n_loops_i, cfg_slot_iter_i,
        input  rcfg_ctrl_addr_o, slot_valid_o, slot_last_o, loop_cnt_o, busy_o, done_o,
               cfg_err_o
    );

    modport slave (
        input  start_i, abort_i, stall_i, cfg_n_slots_i, cfg_n_loops_i, cfg_slot_iter_i,
        output rcfg_ctrl_addr_o, slot_valid_o, slot_last_o, loop_cnt_o, busy_o, done_o,
               cfg_err_o
    );
endinterface

// File: rtl/kmem_rcfg_sequencer_dwell_cnt.sv
// Per-slot dwell counter: counts enabled cycles 0..limit-1 and flags the final one.
module kmem_dwell_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] limit_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // limit_i is at least 1, so limit_i - 1 never underflows.
    assign tc_o = (cnt_q >= (limit_i - W'(1)));

    // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/kmem_rcfg_sequencer.sv
// KMEM configuration-slot sequencer: walks rcfg_ctrl_addr through the active slots,
// dwelling per slot and repeating for a programmed number of loops.
module kmem_rcfg_sequencer #(
    parameter int KMEM_SIZE        = kmem_rcfg_sequencer_pkg::KMEM_SIZE,
    parameter int N_ADDR_BITS_KMEM = $clog2(KMEM_SIZE),
    parameter int ITER_W           = kmem_rcfg_sequencer_pkg::KMEM_ITER_W,
    parameter int LOOP_W           = kmem_rcfg_sequencer_pkg::KMEM_LOOP_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    kmem_rcfg_sequencer_if.slave   bus_if
);
    import kmem_rcfg_sequencer_pkg::*;

    localparam int NS_W = N_ADDR_BITS_KMEM + 1;

    rcfg_seq_state_e               state_q, state_d;
    logic [N_ADDR_BITS_KMEM-1:0]   slot_q, slot_d;
    logic [NS_W-1:0]               n_slots_q, n_slots_d;
    logic [LOOP_W-1:0]             n_loops_q, n_loops_d;
    logic [LOOP_W-1:0]             loop_q, loop_d;
    logic                          err_q, err_d;

    logic [ITER_W-1:0]             iter_cur;
    logic [ITER_W-1:0]             dwell_lim;
    logic [LOOP_W-1:0]             loop_inc;
    logic                          run;
    logic                          dwell_en;
    logic                          dwell_tc;
    logic                          slot_wrap;

    assign run       = (state_q == RCFG_RUN);
    assign dwell_en  = run && !bus_if.stall_i;
    assign iter_cur  = bus_if.cfg_slot_iter_i[slot_q];
    assign dwell_lim = (iter_cur == '0) ? ITER_W'(1) : iter_cur;
    assign slot_wrap = (({1'b0, slot_q} + NS_W'(1)) == n_slots_q);
    assign loop_inc  = loop_q + LOOP_W'(1);

    // Held clear outside RUN so every run and every restart begins at dwell 0.
    kmem_dwell_cnt #(.W(ITER_W)) u_dwell (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .limit_i (dwell_lim),
        .en_i    (dwell_en),
        .clr_i   (!run),
        .tc_o    (dwell_tc)
    );

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        n_slots_d = n_slots_q;
        n_loops_d = n_loops_q;
        loop_d    = loop_q;
        err_d     = err_q;
        unique case (state_q)
            RCFG_IDLE: begin
                if (bus_if.start_i) begin
                    if (bus_if.cfg_n_slots_i > NS_W'(KMEM_SIZE)) begin
                        err_d   = 1'b1;
                        state_d = RCFG_DONE;
                    end else if (bus_if.cfg_n_slots_i == '0) begin
                        state_d = RCFG_DONE;
                    end else begin
                        n_slots_d = bus_if.cfg_n_slots_i;
                        n_loops_d = bus_if.cfg_n_loops_i;
                        err_d     = 1'b0;
                        slot_d    = '0;
                        loop_d    = '0;
                        state_d   = RCFG_RUN;
                    end
                end
            end
            RCFG_RUN: begin
                // Abort wins over both stall and completion.
                if (bus_if.abort_i) begin
                    state_d = RCFG_IDLE;
                end else if (dwell_en && dwell_tc) begin
                    if (!slot_wrap) begin
                        slot_d = slot_q + N_ADDR_BITS_KMEM'(1);
                    end else begin
                        slot_d = '0;
                        loop_d = loop_inc;
                        if ((n_loops_q != '0) && (loop_inc == n_loops_q)) begin
                            state_d = RCFG_DONE;
                        end
                    end
                end
            end
            RCFG_DONE: state_d = RCFG_IDLE;
            default:   state_d = RCFG_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RCFG_IDLE;
            slot_q    <= '0;
            n_slots_q <= '0;
            n_loops_q <= '0;
            loop_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            n_slots_q <= n_slots_d;
            n_loops_q <= n_loops_d;
            loop_q    <= loop_d;
            err_q     <= err_d;
        end
    end

    assign bus_if.rcfg_ctrl_addr_o = run ? slot_q : '0;
    assign bus_if.slot_valid_o     = run;
    assign bus_if.slot_last_o      = dwell_tc && dwell_en;
    assign bus_if.loop_cnt_o       = loop_q;
    assign bus_if.busy_o           = run;
    assign bus_if.done_o           = (state_q == RCFG_DONE);
    assign bus_if.cfg_err_o        = err_q;
endmodule
